// File: rtl/genesis_pad_pkg.sv
// ---------------------------------------------------------------------------
// genesis_pad_pkg
// Shared definitions for the Genesis pad post-processor:
//   - bit positions of the decoded button word {Z,Y,X,M,S,C,B,A,U,D,L,R}
//   - pad type codes reported by the pad reader
//   - turbo-eligible button mask and hotkey combo constants
//   - hotkey FSM state encoding
//   - type_mask(): which buttons a given pad type can physically report
// ---------------------------------------------------------------------------
package genesis_pad_pkg;

  localparam int PAD_W = 12;

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_A = 4;
  localparam int BTN_B = 5;
  localparam int BTN_C = 6;
  localparam int BTN_S = 7;
  localparam int BTN_M = 8;
  localparam int BTN_X = 9;
  localparam int BTN_Y = 10;
  localparam int BTN_Z = 11;

  localparam logic [1:0] PAD_TYPE_MS   = 2'd0;
  localparam logic [1:0] PAD_TYPE_3BTN = 2'd1;
  localparam logic [1:0] PAD_TYPE_6BTN = 2'd2;
  localparam logic [1:0] PAD_TYPE_ERR  = 2'd3;

  // Only the fire buttons may be auto-repeated: A,B,C,X,Y,Z.
  localparam logic [PAD_W-1:0] TURBO_ALLOWED = 12'hE70;

  // Hotkeys look only at S,A,B,C; the remaining buttons are don't-care.
  localparam logic [PAD_W-1:0] COMBO_MASK = (12'd1 << BTN_S) | (12'd1 << BTN_A) |
                                            (12'd1 << BTN_B) | (12'd1 << BTN_C);
  localparam logic [PAD_W-1:0] OSD_MATCH  = (12'd1 << BTN_S) | (12'd1 << BTN_B);
  localparam logic [PAD_W-1:0] RST_MATCH  = COMBO_MASK;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_OSD = 2'd1,
    HOLD_RST = 2'd2,
    FIRED    = 2'd3
  } hotkey_state_t;

  // Buttons that can legitimately be reported by each pad type. A Master
  // System pad only has the d-pad plus two buttons, which the reader maps
  // onto B and C.
  function automatic logic [PAD_W-1:0] type_mask(input logic [1:0] pad_type);
    logic [PAD_W-1:0] m;
    case (pad_type)
      PAD_TYPE_MS:   m = 12'h06F;
      PAD_TYPE_3BTN: m = 12'h0FF;
      PAD_TYPE_6BTN: m = 12'hFFF;
      default:       m = 12'h000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/genesis_debounce_bit.sv
// ---------------------------------------------------------------------------
// genesis_debounce_bit
// Single-bit debouncer. The output only follows the input after the input has
// disagreed with the output for CYCLES consecutive clocks; any return to the
// current output value restarts the count. CYCLES = 0 passes iD straight
// through.
// Ports:
//   iCLK    clock
//   iRESET  synchronous active-high reset (output and counter to 0)
//   iCLR    synchronous clear, same effect as iRESET
//   iD      raw input bit
//   oQ      debounced bit
// ---------------------------------------------------------------------------
module genesis_debounce_bit #(
  parameter int CYCLES = 100_000
) (
  input  logic iCLK,
  input  logic iRESET,
  input  logic iCLR,
  input  logic iD,
  output logic oQ
);

  generate
    if (CYCLES == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{iCLK, iRESET, iCLR};
      assign oQ = iD;
    end else begin : g_filter
      localparam int CW = $clog2(CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

      logic [CW-1:0] cnt_reg;
      logic          q_reg;

      always_ff @(posedge iCLK) begin
        if (iRESET || iCLR) begin
          cnt_reg <= '0;
          q_reg   <= 1'b0;
        end else if (iD == q_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          // This is the CYCLES-th consecutive disagreeing sample.
          q_reg   <= iD;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end

      assign oQ = q_reg;
    end
  endgenerate

endmodule

// File: rtl/genesis_pad_postproc.sv
// ---------------------------------------------------------------------------
// genesis_pad_postproc
// Conditions the decoded Genesis pad word for the core and the OSD:
//   stage 1 : register pad type and type-masked button word
//   debounce: one genesis_debounce_bit per button
//   turbo   : shared square-wave phase gating turbo-enabled fire buttons
//   hotkeys : hold S+B (OSD toggle) or S+A+B+C (soft reset) for a fixed time
// Ports:
//   iCLK          clock
//   iRESET        synchronous active-high reset
//   iPAD_TYPE     2-bit pad type (0 MS/unknown, 1 3-button, 2 6-button, 3 error)
//   iPAD_DECODED  12-bit button word {Z,Y,X,M,S,C,B,A,U,D,L,R}, 1 = pressed
//   iTURBO_MASK   12-bit turbo enable, effective only on A,B,C,X,Y,Z
//   oPAD          12-bit conditioned button word
//   oPAD_VALID    registered pad type is 0..2
//   oOSD_TOGGLE   one-cycle pulse when the OSD hotkey fires
//   oSOFT_RESET   level, RESET_PULSE_CYCLES long, when the reset hotkey fires
//   oTYPE_CHANGE  one-cycle pulse when the pad type changes
// ---------------------------------------------------------------------------
module genesis_pad_postproc
  import genesis_pad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 100_000,
  parameter int TURBO_HALF_CYCLES  = 1_666_667,
  parameter int HOTKEY_HOLD_CYCLES = 50_000_000,
  parameter int RESET_PULSE_CYCLES = 1_000_000
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [1:0]       iPAD_TYPE,
  input  logic [PAD_W-1:0] iPAD_DECODED,
  input  logic [PAD_W-1:0] iTURBO_MASK,
  output logic [PAD_W-1:0] oPAD,
  output logic             oPAD_VALID,
  output logic             oOSD_TOGGLE,
  output logic             oSOFT_RESET,
  output logic             oTYPE_CHANGE
);

  localparam int TW = $clog2(TURBO_HALF_CYCLES + 1);
  localparam int HW = $clog2(HOTKEY_HOLD_CYCLES + 1);
  localparam int PW = $clog2(RESET_PULSE_CYCLES + 1);

  localparam logic [TW-1:0] TURBO_LAST = TW'(TURBO_HALF_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(RESET_PULSE_CYCLES);
  // The hold counter is cleared on the cycle the combo is first seen, so the
  // fire decision is taken when it holds HOLD-2 (it would become HOLD-1 on
  // the firing edge). A hold time of 1 fires on the first hold cycle.
  localparam logic [HW-1:0] HOLD_LAST =
      HW'((HOTKEY_HOLD_CYCLES >= 2) ? (HOTKEY_HOLD_CYCLES - 2) : 0);

  // ---------------- stage 1: type and masked word ----------------
  logic [1:0]       pad_type_reg;
  logic [PAD_W-1:0] masked_reg;
  logic             valid_reg;
  logic             type_chg_reg;
  logic             type_change;

  // Compared against the live input so the clear hits the debouncers on the
  // same edge the new type is registered.
  assign type_change = (iPAD_TYPE != pad_type_reg);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      pad_type_reg <= PAD_TYPE_MS;
      masked_reg   <= '0;
      valid_reg    <= 1'b0;
      type_chg_reg <= 1'b0;
    end else begin
      pad_type_reg <= iPAD_TYPE;
      masked_reg   <= iPAD_DECODED & type_mask(iPAD_TYPE);
      valid_reg    <= (iPAD_TYPE != PAD_TYPE_ERR);
      type_chg_reg <= type_change;
    end
  end

  // ---------------- per-button debounce ----------------
  logic [PAD_W-1:0] stable;

  generate
    for (genvar gi = 0; gi < PAD_W; gi++) begin : g_debounce
      genesis_debounce_bit #(
        .CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iCLR   (type_change),
        .iD     (masked_reg[gi]),
        .oQ     (stable[gi])
      );
    end
  endgenerate

  // ---------------- turbo ----------------
  logic [PAD_W-1:0] eff_mask;
  logic             turbo_active;
  logic [TW-1:0]    turbo_cnt_reg;
  logic             phase_reg;

  assign eff_mask     = iTURBO_MASK & TURBO_ALLOWED;
  assign turbo_active = |(stable & eff_mask);

  // Parked at count 0 / phase 1 while idle so a fresh press starts "on".
  always_ff @(posedge iCLK) begin
    if (iRESET || !turbo_active) begin
      turbo_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else if (turbo_cnt_reg == TURBO_LAST) begin
      turbo_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      turbo_cnt_reg <= turbo_cnt_reg + TW'(1);
    end
  end

  // ---------------- hotkey FSM ----------------
  hotkey_state_t state_reg, state_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          fire_osd;
  logic          fire_rst;
  logic          osd_combo;
  logic          rst_combo;
  logic          hold_done;

  assign osd_combo = ((stable & COMBO_MASK) == OSD_MATCH);
  assign rst_combo = ((stable & COMBO_MASK) == RST_MATCH);
  assign hold_done = (hold_cnt_reg == HOLD_LAST);

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    fire_osd      = 1'b0;
    fire_rst      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (osd_combo) begin
          state_next    = HOLD_OSD;
          hold_cnt_next = '0;
        end else if (rst_combo) begin
          state_next    = HOLD_RST;
          hold_cnt_next = '0;
        end
      end
      HOLD_OSD: begin
        if (rst_combo) begin
          // A and C joined the held S+B: restart timing as a reset request.
          state_next    = HOLD_RST;
          hold_cnt_next = '0;
        end else if (osd_combo) begin
          if (hold_done) begin
            fire_osd   = 1'b1;
            state_next = FIRED;
          end else begin
            hold_cnt_next = hold_cnt_reg + HW'(1);
          end
        end else begin
          state_next = IDLE;
        end
      end
      HOLD_RST: begin
        if (osd_combo) begin
          state_next    = HOLD_OSD;
          hold_cnt_next = '0;
        end else if (rst_combo) begin
          if (hold_done) begin
            fire_rst   = 1'b1;
            state_next = FIRED;
          end else begin
            hold_cnt_next = hold_cnt_reg + HW'(1);
          end
        end else begin
          state_next = IDLE;
        end
      end
      FIRED: begin
        // Re-arm only after every button has been let go.
        if (stable == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (type_change) begin
      state_next    = IDLE;
      hold_cnt_next = '0;
      fire_osd      = 1'b0;
      fire_rst      = 1'b0;
    end
  end

  // ---------------- state, pulses and output word ----------------
  logic [PW-1:0]    pulse_cnt_reg;
  logic             osd_reg;
  logic [PAD_W-1:0] pad_reg;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_reg     <= IDLE;
      hold_cnt_reg  <= '0;
      pulse_cnt_reg <= '0;
      osd_reg       <= 1'b0;
      pad_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      osd_reg      <= fire_osd;

      // A new reset fire reloads, so an active pulse is stretched.
      if (fire_rst) begin
        pulse_cnt_reg <= PULSE_LOAD;
      end else if (pulse_cnt_reg != '0) begin
        pulse_cnt_reg <= pulse_cnt_reg - PW'(1);
      end

      // Buttons are hidden from the core from the firing edge until release
      // so the hotkey itself never reaches the game.
      if (type_change || (state_next == FIRED)) begin
        pad_reg <= '0;
      end else begin
        pad_reg <= stable & (~eff_mask | {PAD_W{phase_reg}});
      end
    end
  end

  assign oPAD         = pad_reg;
  assign oPAD_VALID   = valid_reg;
  assign oOSD_TOGGLE  = osd_reg;
  assign oSOFT_RESET  = (pulse_cnt_reg != '0);
  assign oTYPE_CHANGE = type_chg_reg;

endmodule

// File: tb/tb_genesis_pad_postproc.sv
// ---------------------------------------------------------------------------
// tb_genesis_pad_postproc
// Self-checking bench for genesis_pad_postproc with short timing parameters.
// Expected observations are queued with the cycle they are due and compared
// on the falling edge of that cycle.
// ---------------------------------------------------------------------------
module tb_genesis_pad_postproc;

  localparam int DEB = 4;
  localparam int TH  = 8;
  localparam int HH  = 20;
  localparam int RP  = 10;

  localparam logic [15:0] M_PAD  = 16'h0FFF;
  localparam logic [15:0] M_VAL  = 16'h1000;
  localparam logic [15:0] M_OSD  = 16'h2000;
  localparam logic [15:0] M_SRST = 16'h4000;
  localparam logic [15:0] M_TCHG = 16'h8000;
  localparam logic [15:0] M_ALL  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pad_type;
  logic [11:0] pad_dec;
  logic [11:0] turbo_mask;
  logic [11:0] pad;
  logic        pad_valid;
  logic        osd_toggle;
  logic        soft_reset;
  logic        type_change;
  logic [15:0] obs;

  genesis_pad_postproc #(
    .DEBOUNCE_CYCLES    (DEB),
    .TURBO_HALF_CYCLES  (TH),
    .HOTKEY_HOLD_CYCLES (HH),
    .RESET_PULSE_CYCLES (RP)
  ) dut (
    .iCLK         (clk),
    .iRESET       (rst),
    .iPAD_TYPE    (pad_type),
    .iPAD_DECODED (pad_dec),
    .iTURBO_MASK  (turbo_mask),
    .oPAD         (pad),
    .oPAD_VALID   (pad_valid),
    .oOSD_TOGGLE  (osd_toggle),
    .oSOFT_RESET  (soft_reset),
    .oTYPE_CHANGE (type_change)
  );

  always #5 clk = ~clk;

  assign obs = {type_change, soft_reset, osd_toggle, pad_valid, pad};

  typedef struct {
    int          due;
    string       name;
    logic [15:0] care;
    logic [15:0] val;
  } exp_t;

  typedef struct {
    logic [1:0]  typ;
    logic [11:0] dec;
    logic [11:0] pad;
    logic        vld;
    string       name;
  } vec_t;

  exp_t sb[$];
  int   cyc_n = 0;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [15:0] ov(input logic tchg, input logic srst,
                                     input logic osd, input logic vld,
                                     input logic [11:0] p);
    return {tchg, srst, osd, vld, p};
  endfunction

  task automatic expect_at(input int k, input string nm,
                           input logic [15:0] care, input logic [15:0] val);
    exp_t e;
    e.due  = cyc_n + k;
    e.name = nm;
    e.care = care;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and retire every expectation due now.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc_n) begin
        total++;
        if ((obs & sb[i].care) !== (sb[i].val & sb[i].care)) begin
          bad++;
          $display("FAIL %s @cycle %0d: got %h want %h (care %h)",
                   sb[i].name, cyc_n, obs & sb[i].care,
                   sb[i].val & sb[i].care, sb[i].care);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  vec_t vt[7];

  initial begin
    vt[0] = '{2'd2, 12'h010, 12'h010, 1'b1, "t2_A"};
    vt[1] = '{2'd1, 12'hF10, 12'h010, 1'b1, "t1_mask_zyxm"};
    vt[2] = '{2'd0, 12'h090, 12'h000, 1'b1, "t0_mask_as"};
    vt[3] = '{2'd0, 12'h06F, 12'h06F, 1'b1, "t0_pass"};
    vt[4] = '{2'd3, 12'hFFF, 12'h000, 1'b0, "t3_error"};
    vt[5] = '{2'd2, 12'hE0F, 12'hE0F, 1'b1, "t2_all"};
    vt[6] = '{2'd1, 12'h18F, 12'h08F, 1'b1, "t1_s_dirs"};

    rst        = 1'b1;
    pad_type   = 2'd2;
    pad_dec    = '0;
    turbo_mask = '0;

    // Reset, with a non-zero type already presented.
    cyc();
    $display("seq reset");
    expect_at(1, "reset_outputs", M_ALL, 16'h0000);
    expect_at(2, "reset_outputs", M_ALL, 16'h0000);
    step(2);
    rst = 1'b0;
    expect_at(1, "type_chg_after_reset", M_ALL, ov(1'b1, 1'b0, 1'b0, 1'b1, 12'h000));
    expect_at(2, "type_chg_single", M_TCHG, 16'h0000);
    step(3);

    // Table-driven static masking.
    for (int i = 0; i < 7; i++) begin
      pad_type = vt[i].typ;
      pad_dec  = vt[i].dec;
      $display("vec %0d %s type=%0d in=%h want=%h valid=%0d",
               i, vt[i].name, vt[i].typ, vt[i].dec, vt[i].pad, vt[i].vld);
      expect_at(12, vt[i].name, M_PAD | M_VAL,
                ov(1'b0, 1'b0, 1'b0, vt[i].vld, vt[i].pad));
      step(13);
    end

    // Exact debounce latency.
    pad_type = 2'd2;
    pad_dec  = '0;
    step(12);
    $display("seq latency");
    pad_dec = 12'h010;
    expect_at(5, "latency_before", M_PAD, 16'h0000);
    expect_at(6, "latency_exact", M_PAD, 16'h0010);
    step(10);

    // Short glitch on R.
    pad_dec = '0;
    step(10);
    $display("seq glitch");
    pad_dec = 12'h001;
    for (int k = 1; k <= 12; k++) expect_at(k, "glitch_r", 16'h0001, 16'h0000);
    step(3);
    pad_dec = '0;
    step(12);

    // Turbo on A: 8 high / 8 low, starting high.
    $display("seq turbo_a");
    turbo_mask = 12'h010;
    pad_dec    = 12'h010;
    for (int k = 1; k <= 60; k++) begin
      logic on;
      on = (k >= 6) && ((((k - 6) / TH) % 2) == 0);
      expect_at(k, "turbo_a", M_PAD, {4'h0, 7'h00, on, 4'h0});
    end
    step(60);
    pad_dec = '0;
    step(12);

    // Turbo requested on S, which is not eligible.
    $display("seq turbo_s");
    turbo_mask = 12'h080;
    pad_dec    = 12'h080;
    for (int k = 6; k <= 40; k++) expect_at(k, "turbo_s_const", M_PAD, 16'h0080);
    step(40);
    pad_dec    = '0;
    turbo_mask = '0;
    step(12);

    // OSD hotkey, then re-hold without full release.
    $display("seq osd");
    for (int k = 1; k <= 85; k++) begin
      logic [11:0] p;
      p = (k >= 6 && k <= 24) ? 12'h0A0 : 12'h000;
      expect_at(k, "osd_hotkey", M_PAD | M_OSD | M_SRST,
                ov(1'b0, 1'b0, (k == 25), 1'b0, p));
    end
    pad_dec = 12'h0A0;
    step(25);
    pad_dec = 12'h080;
    step(10);
    pad_dec = 12'h0A0;
    step(40);
    pad_dec = '0;
    step(15);

    // OSD hold upgraded to reset hold.
    $display("seq soft_reset");
    for (int k = 1; k <= 50; k++) begin
      logic [11:0] p;
      if (k < 6)       p = 12'h000;
      else if (k <= 15) p = 12'h0A0;
      else if (k <= 34) p = 12'h0F0;
      else              p = 12'h000;
      expect_at(k, "rst_hotkey", M_PAD | M_OSD | M_SRST,
                ov(1'b0, (k >= 35 && k <= 44), 1'b0, 1'b0, p));
    end
    pad_dec = 12'h0A0;
    step(10);
    pad_dec = 12'h0F0;
    step(25);
    pad_dec = '0;
    step(15);

    // Reset asserted in the middle of a soft-reset pulse.
    $display("seq reset_mid_pulse");
    for (int k = 1; k <= 28; k++)
      expect_at(k, "pulse_before_reset", M_OSD | M_SRST,
                ov(1'b0, (k >= 25), 1'b0, 1'b0, 12'h000));
    expect_at(29, "reset_abort", M_ALL, 16'h0000);
    expect_at(30, "reset_abort", M_ALL, 16'h0000);
    expect_at(31, "type_chg_post_reset", M_ALL, ov(1'b1, 1'b0, 1'b0, 1'b1, 12'h000));
    expect_at(32, "type_chg_post_reset_end", M_TCHG, 16'h0000);
    pad_dec = 12'h0F0;
    step(28);
    rst = 1'b1;
    step(2);
    rst     = 1'b0;
    pad_dec = '0;
    step(4);

    // Type change 1 -> 2 with buttons held.
    $display("seq type_change");
    pad_type = 2'd1;
    pad_dec  = 12'h210;
    expect_at(15, "t1_held", M_PAD, 16'h0010);
    step(16);
    pad_type = 2'd2;
    expect_at(1, "type_change_pulse", M_ALL, ov(1'b1, 1'b0, 1'b0, 1'b1, 12'h000));
    for (int k = 2; k <= 5; k++) expect_at(k, "type_change_blank", M_PAD | M_TCHG, 16'h0000);
    for (int k = 6; k <= 10; k++) expect_at(k, "type_change_back", M_PAD | M_TCHG, 16'h0210);
    step(12);

    // Anything still queued was never reached.
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    while (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: never checked, due cycle %0d now %0d", sb[0].name, sb[0].due, cyc_n);
      sb.delete(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
